// File: rtl/iso14443a_pkg.sv
`default_nettype none
// ============================================================================
// iso14443a_pkg : shared ISO 14443-A PCD->PICC link definitions
// Rev 1.0
// ============================================================================
package iso14443a_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } state_e;

    localparam int ETU_CLKS        = 8;
    localparam int DEFAULT_TIMEOUT = 3 * ETU_CLKS;

endpackage
`default_nettype wire

// File: rtl/iso14443a_deframer_if.sv
`default_nettype none
// ============================================================================
// iso14443a_deframer_if : decoded-bit input and frame-event output bundle
// Rev 1.0
// ============================================================================
interface iso14443a_deframer_if #(
    parameter int CNT_W = 6
);
    logic             in_enable;
    logic             in_bit_valid;
    logic             in_bit;
    logic             out_sof;
    logic [7:0]       out_byte;
    logic             out_byte_valid;
    logic             out_parity_err;
    logic             out_short_frame;
    logic             out_eof;
    logic             out_frame_err;
    logic [CNT_W-1:0] out_byte_count;

    modport master (
        output in_enable, in_bit_valid, in_bit,
        input  out_sof, out_byte, out_byte_valid, out_parity_err,
               out_short_frame, out_eof, out_frame_err, out_byte_count
    );

    modport slave (
        input  in_enable, in_bit_valid, in_bit,
        output out_sof, out_byte, out_byte_valid, out_parity_err,
               out_short_frame, out_eof, out_frame_err, out_byte_count
    );
endinterface
`default_nettype wire

// File: rtl/iso14443a_idle_timer.sv
`default_nettype none
// ============================================================================
// iso14443a_idle_timer : clock counter with clear, enable and terminal flag
// Rev 1.0
// ============================================================================
module iso14443a_idle_timer #(
    parameter int TIMEOUT = 24
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_tc
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          at_limit;

    assign at_limit = (count_q == CW'(TIMEOUT));
    assign o_tc     = at_limit;

    // Holds at the limit so the flag stays up until the owner clears it.
    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable && !at_limit) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/iso14443a_deframer.sv
`default_nettype none
// ============================================================================
// iso14443a_deframer : ISO 14443-A reader-to-tag frame deframer (106 kb/s)
// Rev 1.0
// ============================================================================
module iso14443a_deframer
    import iso14443a_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 6
) (
    input  wire logic           clk,
    input  wire logic           rst,
    iso14443a_deframer_if.slave bus
);
    state_e           state_q,      state_d;
    logic [7:0]       sreg_q,       sreg_d;
    logic [3:0]       bitcnt_q,     bitcnt_d;
    logic [CNT_W-1:0] byte_count_q, byte_count_d;
    logic             sof_q,        sof_d;
    logic [7:0]       byte_q,       byte_d;
    logic             byte_valid_q, byte_valid_d;
    logic             parity_err_q, parity_err_d;
    logic             short_q,      short_d;
    logic             eof_q,        eof_d;
    logic             frame_err_q,  frame_err_d;

    logic strobe;
    logic timer_en;
    logic timer_tc;
    logic have_bytes;
    logic count_max;

    assign strobe     = bus.in_enable && bus.in_bit_valid;
    assign timer_en   = bus.in_enable && (state_q != ST_IDLE);
    assign have_bytes = (byte_count_q != '0);
    assign count_max  = (byte_count_q == {CNT_W{1'b1}});

    iso14443a_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (strobe || !timer_en),
        .i_enable (timer_en),
        .o_tc     (timer_tc)
    );

    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        bitcnt_d     = bitcnt_q;
        byte_count_d = byte_count_q;
        byte_d       = byte_q;
        sof_d        = 1'b0;
        byte_valid_d = 1'b0;
        parity_err_d = 1'b0;
        short_d      = 1'b0;
        eof_d        = 1'b0;
        frame_err_d  = 1'b0;

        if (!bus.in_enable) begin
            state_d      = ST_IDLE;
            sreg_d       = '0;
            bitcnt_d     = '0;
            byte_count_d = '0;
            byte_d       = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (strobe && !bus.in_bit) begin
                        sof_d        = 1'b1;
                        sreg_d       = '0;
                        bitcnt_d     = '0;
                        byte_count_d = '0;
                        state_d      = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (strobe) begin
                        sreg_d   = {bus.in_bit, sreg_q[7:1]};
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd7) begin
                            state_d = ST_PARITY;
                        end
                    end else if (timer_tc) begin
                        // A single trailing 0 is the end-of-communication symbol.
                        eof_d       = 1'b1;
                        state_d     = ST_IDLE;
                        frame_err_d = !(have_bytes &&
                                        ((bitcnt_q == 4'd0) ||
                                         ((bitcnt_q == 4'd1) && !sreg_q[7])));
                    end
                end
                ST_PARITY: begin
                    if (strobe) begin
                        byte_d       = sreg_q;
                        byte_valid_d = 1'b1;
                        parity_err_d = (bus.in_bit != ~^sreg_q);
                        bitcnt_d     = '0;
                        state_d      = ST_DATA;
                        if (!count_max) begin
                            byte_count_d = byte_count_q + CNT_W'(1);
                        end
                    end else if (timer_tc) begin
                        eof_d   = 1'b1;
                        state_d = ST_IDLE;
                        // 7 data bits plus the EOC 0 already sit in sreg.
                        if (!have_bytes && !sreg_q[7]) begin
                            byte_d       = {1'b0, sreg_q[6:0]};
                            byte_valid_d = 1'b1;
                            short_d      = 1'b1;
                            byte_count_d = CNT_W'(1);
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sreg_q       <= '0;
            bitcnt_q     <= '0;
            byte_count_q <= '0;
            sof_q        <= 1'b0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            short_q      <= 1'b0;
            eof_q        <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            bitcnt_q     <= bitcnt_d;
            byte_count_q <= byte_count_d;
            sof_q        <= sof_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            parity_err_q <= parity_err_d;
            short_q      <= short_d;
            eof_q        <= eof_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.out_sof         = sof_q;
    assign bus.out_byte        = byte_q;
    assign bus.out_byte_valid  = byte_valid_q;
    assign bus.out_parity_err  = parity_err_q;
    assign bus.out_short_frame = short_q;
    assign bus.out_eof         = eof_q;
    assign bus.out_frame_err   = frame_err_q;
    assign bus.out_byte_count  = byte_count_q;
endmodule
`default_nettype wire

// File: tb/tb_iso14443a_deframer.sv
`default_nettype none
// ============================================================================
// tb_iso14443a_deframer : randomized + directed bench with a frame-level model
// Rev 1.0
// ============================================================================
module tb_iso14443a_deframer;
    localparam int TO    = 24;
    localparam int CNT_W = 6;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    iso14443a_deframer_if #(.CNT_W(CNT_W)) bus ();

    iso14443a_deframer #(
        .TIMEOUT (TO),
        .CNT_W   (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: frame rules over a bit queue ----------
    logic       mbits[$];
    bit         in_frame = 0;
    int         nbytes = 0;
    int         idle = 0;
    int         cyc = 0;
    logic       e_sof = 0, e_bv = 0, e_perr = 0, e_short = 0, e_eof = 0, e_ferr = 0;
    logic [7:0] e_byte = 0;
    int         e_cnt = 0;

    // monitor of observed events, used by the literal directed checks
    int         n_sof = 0, n_bv = 0, n_eof = 0;
    logic [7:0] last_byte = 0;
    logic       last_perr = 0, last_short = 0, last_ferr = 0, bv_with_eof = 0;
    int         last_cnt = 0, last_strobe = 0, eof_gap = 0;

    task automatic model_clear();
        in_frame = 0; mbits.delete(); nbytes = 0; idle = 0;
        e_sof = 0; e_bv = 0; e_perr = 0; e_short = 0; e_eof = 0; e_ferr = 0;
        e_byte = 0; e_cnt = 0;
    endtask

    always @(posedge rst) model_clear();

    always @(negedge clk) begin
        logic [7:0] v;
        cyc++;
        check("sof", bus.out_sof, e_sof);
        check("byte_valid", bus.out_byte_valid, e_bv);
        check("eof", bus.out_eof, e_eof);
        check("byte", bus.out_byte, e_byte);
        check("byte_count", bus.out_byte_count, e_cnt);
        if (e_bv) begin
            check("parity_err", bus.out_parity_err, e_perr);
            check("short_frame", bus.out_short_frame, e_short);
        end
        if (e_eof) check("frame_err", bus.out_frame_err, e_ferr);

        if (bus.out_sof) n_sof++;
        if (bus.out_byte_valid) begin
            n_bv++; last_byte = bus.out_byte; last_perr = bus.out_parity_err;
            last_short = bus.out_short_frame; bv_with_eof = bus.out_eof;
        end
        if (bus.out_eof) begin
            n_eof++; last_ferr = bus.out_frame_err; last_cnt = int'(bus.out_byte_count);
            eof_gap = cyc - last_strobe;
        end

        // expectations for the outputs after the coming clock edge
        e_sof = 0; e_bv = 0; e_perr = 0; e_short = 0; e_eof = 0; e_ferr = 0;
        if (rst || !bus.in_enable) begin
            model_clear();
        end else if (bus.in_bit_valid) begin
            last_strobe = cyc;
            idle = 0;
            if (!in_frame) begin
                if (bus.in_bit == 1'b0) begin
                    in_frame = 1; e_sof = 1; mbits.delete(); nbytes = 0; e_cnt = 0;
                end
            end else begin
                mbits.push_back(bus.in_bit);
                if (mbits.size() == 9) begin
                    v = '0;
                    for (int i = 0; i < 8; i++) v[i] = mbits[i];
                    e_byte = v; e_bv = 1;
                    // odd parity: the nine bits must hold an odd number of ones
                    e_perr = (($countones(v) + int'(mbits[8])) % 2) == 0;
                    nbytes++;
                    e_cnt = (nbytes > SAT) ? SAT : nbytes;
                    mbits.delete();
                end
            end
        end else if (in_frame) begin
            idle++;
            if (idle == TO + 1) begin
                in_frame = 0; e_eof = 1;
                if (nbytes > 0 && (mbits.size() == 0 ||
                                   (mbits.size() == 1 && mbits[0] == 1'b0))) begin
                    e_ferr = 0;
                end else if (nbytes == 0 && mbits.size() == 8 && mbits[7] == 1'b0) begin
                    v = '0;
                    for (int i = 0; i < 7; i++) v[i] = mbits[i];
                    e_byte = v; e_bv = 1; e_short = 1; e_cnt = 1;
                end else begin
                    e_ferr = 1;
                end
            end
        end
    end

    // ---------------- stimulus ------------------------------------------------
    logic txq[$];

    task automatic clr_mon();
        n_sof = 0; n_bv = 0; n_eof = 0; bv_with_eof = 0;
    endtask

    task automatic idle_clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic strobe(input logic b, input int gap);
        @(posedge clk); #1;
        bus.in_bit_valid = 1'b1; bus.in_bit = b;
        @(posedge clk); #1;
        bus.in_bit_valid = 1'b0; bus.in_bit = 1'($urandom);
        repeat (gap) @(posedge clk);
    endtask

    task automatic push_byte(input logic [7:0] b, input logic good_par);
        for (int i = 0; i < 8; i++) txq.push_back(b[i]);
        txq.push_back(good_par ? ~^b : ^b);
    endtask

    task automatic send_q();
        int g;
        while (txq.size() > 0) begin
            g = ($urandom_range(0, 15) == 0) ? TO - 1 : int'($urandom_range(0, 4));
            strobe(txq.pop_front(), g);
        end
    endtask

    task automatic en_pulse();
        @(posedge clk); #1 bus.in_enable = 1'b0;
        @(posedge clk); #1 bus.in_enable = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        int kind, nb;
        bus.in_enable = 1'b1; bus.in_bit_valid = 1'b0; bus.in_bit = 1'b0;
        idle_clks(3);
        @(posedge clk); #2 rst = 1'b0;
        idle_clks(2); #1;
        check("reset_sof", bus.out_sof, 0);
        check("reset_byte", bus.out_byte, 0);
        check("reset_bv", bus.out_byte_valid, 0);
        check("reset_eof", bus.out_eof, 0);
        check("reset_cnt", bus.out_byte_count, 0);

        // REQA short frame
        clr_mon();
        txq = '{1'b0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0, 1'b0};
        send_q(); idle_clks(40);
        check("reqa_sof", n_sof, 1);
        check("reqa_bv", n_bv, 1);
        check("reqa_byte", last_byte, 8'h26);
        check("reqa_short", last_short, 1);
        check("reqa_bv_with_eof", bv_with_eof, 1);
        check("reqa_ferr", last_ferr, 0);
        check("reqa_cnt", last_cnt, 1);
        // last strobe edge to eof edge is TIMEOUT+1 clocks; sampled one negedge later
        check("reqa_eof_gap", eof_gap, 26);

        // 0x93 good parity + EOC, then bad parity
        for (int p = 1; p >= 0; p--) begin
            clr_mon();
            txq = '{1'b0}; push_byte(8'h93, p[0]); txq.push_back(1'b0);
            send_q(); idle_clks(40);
            check("b93_byte", last_byte, 8'h93);
            check("b93_perr", last_perr, p[0] ? 0 : 1);
            check("b93_eof", n_eof, 1);
            check("b93_ferr", last_ferr, 0);
            check("b93_cnt", last_cnt, 1);
        end

        // two bytes, no EOC
        clr_mon();
        txq = '{1'b0}; push_byte(8'h93, 1); push_byte(8'h20, 1);
        send_q(); idle_clks(40);
        check("two_bv", n_bv, 2);
        check("two_byte", last_byte, 8'h20);
        check("two_perr", last_perr, 0);
        check("two_cnt", last_cnt, 2);
        check("two_ferr", last_ferr, 0);

        // truncated after SOC + 4 bits
        clr_mon();
        txq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        send_q(); idle_clks(40);
        check("trunc_eof", n_eof, 1);
        check("trunc_ferr", last_ferr, 1);
        check("trunc_bv", n_bv, 0);

        // reset in the middle of the second byte
        txq = '{1'b0}; push_byte(8'h93, 1); txq.push_back(1'b1); txq.push_back(1'b0);
        send_q();
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check("rst_byte", bus.out_byte, 0);
        check("rst_cnt", bus.out_byte_count, 0);
        check("rst_bv", bus.out_byte_valid, 0);
        @(posedge clk); #2 rst = 1'b0;
        idle_clks(3);
        clr_mon();
        txq = '{1'b0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0, 1'b0};
        send_q(); idle_clks(40);
        check("post_rst_byte", last_byte, 8'h26);
        check("post_rst_eof", n_eof, 1);

        // parity strobe lands exactly when the idle timer hits TIMEOUT
        clr_mon();
        strobe(1'b0, 1);
        for (int i = 0; i < 8; i++) strobe(rb_93(i), (i == 7) ? TO - 1 : 1);
        strobe(1'b1, 0);
        idle_clks(40);
        check("coll_bv", n_bv, 1);
        check("coll_byte", last_byte, 8'h93);
        check("coll_eof", n_eof, 1);
        check("coll_ferr", last_ferr, 0);

        // byte counter saturation
        clr_mon();
        txq = '{1'b0};
        for (int i = 0; i < SAT + 3; i++) push_byte(8'($urandom), 1);
        send_q(); idle_clks(40);
        check("sat_bv", n_bv, SAT + 3);
        check("sat_cnt", last_cnt, SAT);

        // enable low for one clock aborts without eof
        clr_mon();
        txq = '{1'b0, 1'b1, 1'b1, 1'b0};
        send_q(); en_pulse(); idle_clks(40);
        check("abort_eof", n_eof, 0);

        // randomized frames, checked cycle by cycle against the model
        for (int f = 0; f < 60; f++) begin
            kind = $urandom_range(0, 9);
            txq.delete();
            if (kind == 8) begin
                for (int i = 0; i < int'($urandom_range(1, 3)); i++) txq.push_back(1'b1);
            end
            txq.push_back(1'b0);
            if (kind == 6) begin
                rb = 8'($urandom);
                for (int i = 0; i < 7; i++) txq.push_back(rb[i]);
                txq.push_back(1'b0);
            end else if (kind == 7 || kind == 9) begin
                for (int i = 0; i < int'($urandom_range(0, 12)); i++) txq.push_back(1'($urandom));
            end else begin
                nb = $urandom_range(1, 3);
                for (int i = 0; i < nb; i++) push_byte(8'($urandom), $urandom_range(0, 4) != 0);
                if ($urandom_range(0, 1) == 1) txq.push_back(1'b0);
            end
            send_q();
            if (kind == 9) en_pulse();
            idle_clks($urandom_range(30, 40));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic logic rb_93(input int i);
        logic [7:0] b;
        b = 8'h93;
        return b[i];
    endfunction
endmodule
`default_nettype wire

// File: doc/iso14443a_deframer.md
# iso14443a_deframer

Frame deframer for the ISO 14443-A reader-to-tag (PCD→PICC) link at 106 kb/s. It sits directly downstream of the Modified Miller decoder and consumes the decoder's NRZ-L bit stream, one strobe per ETU. It detects start-of-communication, assembles LSB-first data bytes and checks their odd parity. It also detects end of frame by idle timeout and recognises 7-bit short frames such as REQA and WUPA.

## Interface
- TIMEOUT, 24: clocks with no bit strobe that end a frame (3 ETU at 8 clk/ETU).
- CNT_W, 6: width of the byte counter; the counter saturates at 2^CNT_W-1.
- clk  in  1  847.5 kHz (fc/16) system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_enable  in  1  low → synchronous clear to IDLE, all outputs 0.
- in_bit_valid  in  1  one-cycle strobe: in_bit holds a decoded bit.
- in_bit  in  1  decoded NRZ-L bit, sampled only when in_bit_valid=1.
- out_sof  out  1  one-cycle pulse: frame started.
- out_byte  out  8  received byte; holds its value between strobes.
- out_byte_valid  out  1  one-cycle pulse: out_byte is new.
- out_parity_err  out  1  qualified by out_byte_valid: parity mismatch.
- out_short_frame  out  1  qualified by out_byte_valid: 7-bit frame.
- out_eof  out  1  one-cycle pulse: frame ended.
- out_frame_err  out  1  qualified by out_eof: malformed ending.
- out_byte_count  out  CNT_W  bytes delivered in the current or last frame; stable from out_eof until the next out_sof.

## Operation
- States are IDLE, DATA and PARITY. The registers are sreg[7:0], bitcnt[3:0], byte_count and idle_cnt.
- IDLE
  - A strobe with in_bit=0 is the SOC. It pulses out_sof, clears bitcnt, byte_count and sreg, then enters DATA.
  - A strobe with in_bit=1 is ignored.
- DATA
  - Each strobe shifts right: sreg ← {in_bit, sreg[7:1]}, and bitcnt increments.
  - After the 8th bit the block enters PARITY.
- PARITY
  - On a strobe: out_byte←sreg, out_byte_valid=1, out_parity_err=(in_bit != ~^sreg), out_short_frame=0.
  - byte_count then increments, saturating.
  - bitcnt is cleared and the block returns to DATA.
- Idle timer
  - Active in DATA and PARITY. It clears on every strobe and otherwise increments.
  - When it reaches TIMEOUT, the block evaluates the ending rules below, pulses out_eof and goes to IDLE.
- Ending rules, evaluated at the timeout:
  - DATA, bitcnt=0, byte_count>0: normal end, out_frame_err=0.
  - DATA, bitcnt=1, last bit 0, byte_count>0: EOC logic-0 absorbed, out_frame_err=0.
  - PARITY, byte_count=0, sreg[7]=0: short frame.
    - out_byte={1'b0, sreg[6:0]}, out_byte_valid=1 and out_short_frame=1, in the same cycle as out_eof.
    - byte_count becomes 1.
  - Any other combination: out_frame_err=1, with no byte emitted.
- in_enable low for one clock aborts any frame without an out_eof pulse.

## Timing
- Reset values: all outputs 0, state IDLE, all counters 0.
  - rst acts immediately; its release is synchronous.
  - Reset mid-frame discards the partial byte.
- Latency:
  - out_sof is asserted on the clock after the SOC strobe.
  - out_byte_valid is asserted on the clock after the parity strobe.
- out_eof is asserted exactly TIMEOUT+1 clocks after the last strobe cycle.
- If a strobe coincides with the idle timer reaching TIMEOUT, the strobe wins: it is processed and the timer clears.
- Strobes arrive at most once per 2 clocks, and a registered-output implementation must not need more.
- All outputs are registered; none is combinational from the inputs.

## Structure
- Shared package iso14443a_pkg holds:
  - the state encoding (IDLE/DATA/PARITY);
  - ETU_CLKS=8;
  - the default TIMEOUT.
  - The Miller decoder and future framer reuse it.
- Sub-module iso14443a_idle_timer: a counter with clear, enable and a terminal-count flag, parameterised by TIMEOUT.
- Parity is a single XNOR reduction kept inline.

## Test plan
- REQA 0x26, stream 0 | 0,1,1,0,0,1,0 | 0, then idle:
  - out_sof;
  - after 25 idle clocks, out_byte=0x26 with out_byte_valid, out_short_frame=1 and out_eof, all in one cycle;
  - out_frame_err=0, out_byte_count=1.
- Byte 0x93, stream SOC | 1,1,0,0,1,0,0,1 | parity 1 | EOC 0:
  - out_byte=0x93 with out_parity_err=0;
  - out_eof with out_frame_err=0, out_byte_count=1.
- Same stream with parity bit 0 → out_parity_err=1 and out_eof normal.
- Two bytes 0x93, 0x20 with correct parity (0 for 0x20), then idle → two out_byte_valid pulses and out_byte_count=2.
- Frame truncated after SOC plus 4 bits → out_eof with out_frame_err=1 and no out_byte_valid.
- Reset cases:
  - rst mid-byte → outputs 0 immediately.
  - The next valid frame decodes correctly.
- Timeout collision: a strobe exactly at idle_cnt=TIMEOUT → no out_eof, and the bit is accepted.
